multicycle_control: RTL

//  Multi-cycle control FSM for the MIPS-subset datapath; drives the ALU from the issuing side.

---
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundles the control/datapath signals of the multi-cycle MIPS-subset core.
//   master : the control FSM (drives selects/enables, reads Instr/ALU_zero/Mem_Ack)
//   slave  : the datapath side (PC, IR, RF, ALU, data memory)
//
//   Handshake with data memory: Mem_RdEn / Mem_WrEn are held high as a request
//   until Mem_Ack is seen high on a rising Clk edge; that edge completes the
//   transfer and the request drops on the same edge. Mem_Ack is a one-cycle
//   done strobe and is meaningless while no request is outstanding.
interface multicycle_control_if;
    logic [31:0] Instr;
    logic        ALU_zero;
    logic        Mem_Ack;

    logic        PC_LdEn;
    logic        PC_sel;
    logic        IR_LdEn;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        RF_B_sel;
    logic        ALU_Bin_sel;
    logic        Imm_zext;
    logic [3:0]  ALU_func;
    logic        Mem_RdEn;
    logic        Mem_WrEn;
    logic        Err;

    modport master (
        input  Instr, ALU_zero, Mem_Ack,
        output PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
               ALU_Bin_sel, Imm_zext, ALU_func, Mem_RdEn, Mem_WrEn, Err
    );

    modport slave (
        output Instr, ALU_zero, Mem_Ack,
        input  PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
               ALU_Bin_sel, Imm_zext, ALU_func, Mem_RdEn, Mem_WrEn, Err
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for the multi-cycle MIPS-subset datapath. Sequences
//   fetch / decode / execute / memory / writeback and drives the datapath
//   selects, enables and ALU operation code.
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous active-high reset (state RST, outputs 0)
//   bus        if   multicycle_control_if.master (Instr, ALU_zero, Mem_Ack in;
//                   all datapath controls and Err out)
//   dbg_state  out  current FSM state encoding (state_t order)
// Parameters
//   MEM_TIMEOUT  wait cycles allowed for Mem_Ack in MEM_RD/MEM_WR (1..255)
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                        Clk,
    input  logic                        Reset,
    multicycle_control_if.master        bus,
    output logic [3:0]                  dbg_state
);

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_IF       = 4'd1,
        S_ID       = 4'd2,
        S_EX_R     = 4'd3,
        S_EX_I     = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB       = 4'd8,
        S_BR       = 4'd9,
        S_ERR      = 4'd10
    } state_t;

    localparam logic [5:0] OP_R    = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SW   = 6'b011111;
    localparam logic [5:0] OP_BEQ  = 6'b010000;
    localparam logic [5:0] OP_BNE  = 6'b010001;

    // Last counter value at which a missing Mem_Ack is still tolerated.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, nxt_state;
    logic [7:0] wait_cnt, nxt_cnt;

    // Registered outputs and their next values.
    logic       pc_ld_q, ir_ld_q, rf_wr_q, rf_wds_q, rf_bsel_q, bin_q, zext_q;
    logic       rd_q, wr_q, err_q;
    logic [3:0] func_q;
    logic       n_pc_ld, n_ir_ld, n_rf_wr, n_rf_wds, n_rf_bsel, n_bin, n_zext;
    logic       n_rd, n_wr, n_err;
    logic [3:0] n_func;

    // Instruction decode.
    logic [5:0] opcode;
    logic [3:0] func_lo;
    logic       is_r, is_imm, is_mem, is_br, is_lw, func_ok, br_take;
    logic       unused_instr_bits;

    assign opcode  = bus.Instr[31:26];
    assign func_lo = bus.Instr[3:0];
    assign unused_instr_bits = ^bus.Instr[25:4];

    assign is_r   = (opcode == OP_R);
    assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
    assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_lw  = (opcode == OP_LW);

    always_comb begin
        func_ok = 1'b0;
        case (func_lo)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101: func_ok = 1'b1;
            default: func_ok = 1'b0;
        endcase
    end

    // ALU_zero is produced by the ALU during BR itself, so the branch decision
    // cannot be registered ahead of time; it is the only output path that is
    // combinational from an input, and it is gated by the registered state.
    assign br_take = (state == S_BR) &&
                     (((opcode == OP_BEQ) &&  bus.ALU_zero) ||
                      ((opcode == OP_BNE) && !bus.ALU_zero));

    // Next state, wait counter, and the output values of the state being entered.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = '0;
        case (state)
            S_RST:      nxt_state = S_IF;
            S_IF:       nxt_state = S_ID;
            S_ID: begin
                if (is_r)        nxt_state = func_ok ? S_EX_R : S_ERR;
                else if (is_imm) nxt_state = S_EX_I;
                else if (is_mem) nxt_state = S_MEM_ADDR;
                else if (is_br)  nxt_state = S_BR;
                else             nxt_state = S_ERR;
            end
            S_EX_R, S_EX_I: nxt_state = S_WB;
            S_MEM_ADDR: nxt_state = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD, S_MEM_WR: begin
                if (bus.Mem_Ack)              nxt_state = (state == S_MEM_RD) ? S_WB : S_IF;
                else if (wait_cnt == TO_LAST) nxt_state = S_ERR;
                else                          nxt_cnt   = wait_cnt + 8'd1;
            end
            S_WB, S_BR: nxt_state = S_IF;
            S_ERR:      nxt_state = S_ERR;
            default:    nxt_state = S_ERR;
        endcase

        n_pc_ld   = 1'b0;
        n_ir_ld   = 1'b0;
        n_rf_wr   = 1'b0;
        n_rf_wds  = 1'b0;
        n_rf_bsel = 1'b0;
        n_bin     = 1'b0;
        n_zext    = 1'b0;
        n_func    = 4'b0000;
        n_rd      = 1'b0;
        n_wr      = 1'b0;
        n_err     = 1'b0;
        case (nxt_state)
            S_IF: begin
                n_ir_ld = 1'b1;
                n_pc_ld = 1'b1;
            end
            S_EX_R: n_func = func_lo;
            S_EX_I: begin
                n_bin  = 1'b1;
                n_zext = (opcode == OP_ANDI) || (opcode == OP_ORI);
                case (opcode)
                    OP_ANDI: n_func = 4'b0010;
                    OP_ORI:  n_func = 4'b0011;
                    default: n_func = 4'b0000;
                endcase
            end
            S_MEM_ADDR: n_bin = 1'b1;
            S_MEM_RD: begin
                n_bin = 1'b1;
                n_rd  = 1'b1;
            end
            S_MEM_WR: begin
                n_bin     = 1'b1;
                n_wr      = 1'b1;
                n_rf_bsel = 1'b1;
            end
            S_WB: begin
                // ALU controls carry over from the execute/memory state so the
                // result being written stays stable during the write.
                n_rf_wr   = 1'b1;
                n_rf_wds  = (state == S_MEM_RD);
                n_func    = func_q;
                n_bin     = bin_q;
                n_zext    = zext_q;
                n_rf_bsel = rf_bsel_q;
            end
            S_BR: begin
                n_func    = 4'b0001;
                n_rf_bsel = 1'b1;
            end
            S_ERR:   n_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_RST;
            wait_cnt  <= '0;
            pc_ld_q   <= 1'b0;
            ir_ld_q   <= 1'b0;
            rf_wr_q   <= 1'b0;
            rf_wds_q  <= 1'b0;
            rf_bsel_q <= 1'b0;
            bin_q     <= 1'b0;
            zext_q    <= 1'b0;
            func_q    <= 4'b0000;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= nxt_state;
            wait_cnt  <= nxt_cnt;
            pc_ld_q   <= n_pc_ld;
            ir_ld_q   <= n_ir_ld;
            rf_wr_q   <= n_rf_wr;
            rf_wds_q  <= n_rf_wds;
            rf_bsel_q <= n_rf_bsel;
            bin_q     <= n_bin;
            zext_q    <= n_zext;
            func_q    <= n_func;
            rd_q      <= n_rd;
            wr_q      <= n_wr;
            err_q     <= n_err;
        end
    end

    assign bus.PC_LdEn       = pc_ld_q | br_take;
    assign bus.PC_sel        = br_take;
    assign bus.IR_LdEn       = ir_ld_q;
    assign bus.RF_WrEn       = rf_wr_q;
    assign bus.RF_WrData_sel = rf_wds_q;
    assign bus.RF_B_sel      = rf_bsel_q;
    assign bus.ALU_Bin_sel   = bin_q;
    assign bus.Imm_zext      = zext_q;
    assign bus.ALU_func      = func_q;
    assign bus.Mem_RdEn      = rd_q;
    assign bus.Mem_WrEn      = wr_q;
    assign bus.Err           = err_q;
    assign dbg_state         = state;

endmodule
